// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, stalls and flushes,
// a mult/div busy scoreboard and saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_to_reg_e,
  input  logic              mem_to_reg_m,
  input  logic              branch_d,
  input  logic              branch_taken_d,
  input  logic              md_start_e,
  input  logic              md_use_d,
  input  logic              cnt_clr,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              forward_a_d,
  output logic              forward_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MdW = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic matchE;
  logic matchM;
  logic loadUse;
  logic branchStall;
  logic mdStall;
  logic stall;
  logic flushD;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  // M is checked first: it holds the newer value of a register written twice in flight.
  always_comb begin
    forward_a_e = 2'b00;
    if (rs_e != '0 && rs_e == write_reg_m && reg_write_m) begin
      forward_a_e = 2'b10;
    end else if (rs_e != '0 && rs_e == write_reg_w && reg_write_w) begin
      forward_a_e = 2'b01;
    end
    forward_b_e = 2'b00;
    if (rt_e != '0 && rt_e == write_reg_m && reg_write_m) begin
      forward_b_e = 2'b10;
    end else if (rt_e != '0 && rt_e == write_reg_w && reg_write_w) begin
      forward_b_e = 2'b01;
    end
  end

  assign forward_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m && !mem_to_reg_m;
  assign forward_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m && !mem_to_reg_m;

  assign matchE = (write_reg_e != '0) && ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign matchM = (write_reg_m != '0) && ((write_reg_m == rs_d) || (write_reg_m == rt_d));

  assign loadUse     = mem_to_reg_e && matchE;
  assign branchStall = branch_d && ((reg_write_e && matchE) || (mem_to_reg_m && matchM));
  assign mdStall     = md_use_d && md_busy;
  assign stall       = loadUse || branchStall || mdStall;

  // A stalled branch has stale operands, so its outcome must not squash anything yet.
  assign flushD = branch_d && branch_taken_d && !stall;

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = flushD;

  generate
    if (MD_LAT > 0) begin : gMd
      logic [MdW-1:0] mdCnt_q, mdCnt_d;

      // A new issue reloads the full latency even if the unit is still busy.
      always_comb begin
        mdCnt_d = mdCnt_q;
        if (md_start_e) begin
          mdCnt_d = MdW'(MD_LAT);
        end else if (mdCnt_q != '0) begin
          mdCnt_d = mdCnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mdCnt_q <= '0;
        end else begin
          mdCnt_q <= mdCnt_d;
        end
      end

      assign md_busy = (mdCnt_q != '0);
    end else begin : gNoMd
      assign md_busy = 1'b0;
    end
  endgenerate

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (cnt_clr) begin
      stallCnt_d = '0;
      flushCnt_d = '0;
    end else begin
      if (stall && stallCnt_q != CntMax) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
      if (flushD && flushCnt_q != CntMax) begin
        flushCnt_d = flushCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard, checked against a cycle-level
// model that tracks the last mult/div issue time and plain integer event counts.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
  logic rwE, rwM, rwW, mtrE, mtrM, brD, brTakenD, mdStartE, mdUseD, cntClr;

  logic [1:0] fwdAE, fwdBE;
  logic fwdAD, fwdBD, stallF, stallD, flushD, flushE, mdBusy;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  logic [1:0] satFwdAE, satFwdBE;
  logic satFwdAD, satFwdBD, satStallF, satStallD, satFlushD, satFlushE, satMdBusy;
  logic [SAT_W-1:0] satStallCnt, satFlushCnt;

  hazard_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rsD), .rt_d(rtD), .rs_e(rsE), .rt_e(rtE),
    .write_reg_e(wrE), .write_reg_m(wrM), .write_reg_w(wrW),
    .reg_write_e(rwE), .reg_write_m(rwM), .reg_write_w(rwW),
    .mem_to_reg_e(mtrE), .mem_to_reg_m(mtrM), .branch_d(brD), .branch_taken_d(brTakenD),
    .md_start_e(mdStartE), .md_use_d(mdUseD), .cnt_clr(cntClr),
    .forward_a_e(fwdAE), .forward_b_e(fwdBE), .forward_a_d(fwdAD), .forward_b_d(fwdBD),
    .stall_f(stallF), .stall_d(stallD), .flush_d(flushD), .flush_e(flushE),
    .md_busy(mdBusy), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  hazard_scoreboard #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(SAT_W)) dutSat (
    .clk(clk), .rst_n(rst_n), .rs_d(rsD), .rt_d(rtD), .rs_e(rsE), .rt_e(rtE),
    .write_reg_e(wrE), .write_reg_m(wrM), .write_reg_w(wrW),
    .reg_write_e(rwE), .reg_write_m(rwM), .reg_write_w(rwW),
    .mem_to_reg_e(mtrE), .mem_to_reg_m(mtrM), .branch_d(brD), .branch_taken_d(brTakenD),
    .md_start_e(mdStartE), .md_use_d(mdUseD), .cnt_clr(cntClr),
    .forward_a_e(satFwdAE), .forward_b_e(satFwdBE), .forward_a_d(satFwdAD), .forward_b_d(satFwdBD),
    .stall_f(satStallF), .stall_d(satStallD), .flush_d(satFlushD), .flush_e(satFlushE),
    .md_busy(satMdBusy), .stall_cnt(satStallCnt), .flush_cnt(satFlushCnt)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Model state: time of the last accepted mult/div issue and unbounded event tallies.
  int  cycleNum = 0;
  bit  mdValid = 1'b0;
  int  mdStartCycle = 0;
  int  stallEvents = 0;
  int  flushEvents = 0;
  int  satStallEvents = 0;
  int  satFlushEvents = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  function automatic logic [1:0] modelFwdE(input logic [REG_AW-1:0] src);
    if (src != 0 && rwM && src == wrM) return 2'b10;
    if (src != 0 && rwW && src == wrW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit readsInD(input logic [REG_AW-1:0] r);
    return (r != 0) && (r == rsD || r == rtD);
  endfunction

  function automatic bit modelBusy();
    return mdValid && (cycleNum - mdStartCycle >= 1) && (cycleNum - mdStartCycle <= MD_LAT);
  endfunction

  function automatic bit modelStall();
    bit loadHazard, branchHazard, mdHazard;
    loadHazard   = mtrE && readsInD(wrE);
    branchHazard = brD && ((rwE && readsInD(wrE)) || (mtrM && readsInD(wrM)));
    mdHazard     = mdUseD && modelBusy();
    return loadHazard || branchHazard || mdHazard;
  endfunction

  task automatic clearInputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0; wrE = '0; wrM = '0; wrW = '0;
    rwE = 0; rwM = 0; rwW = 0; mtrE = 0; mtrM = 0; brD = 0; brTakenD = 0;
    mdStartE = 0; mdUseD = 0; cntClr = 0; rst_n = 1'b1;
  endtask

  // Inputs are already driven; check at the falling edge, then advance the model one cycle.
  task automatic applyStimulus();
    bit expStall, expFlush;
    @(negedge clk);
    expStall = modelStall();
    expFlush = brD && brTakenD && !expStall;
    checkOutput("forward_a_e", 32'(fwdAE), 32'(modelFwdE(rsE)));
    checkOutput("forward_b_e", 32'(fwdBE), 32'(modelFwdE(rtE)));
    checkOutput("forward_a_d", 32'(fwdAD), 32'(rsD != 0 && rsD == wrM && rwM && !mtrM));
    checkOutput("forward_b_d", 32'(fwdBD), 32'(rtD != 0 && rtD == wrM && rwM && !mtrM));
    checkOutput("stall_f", 32'(stallF), 32'(expStall));
    checkOutput("stall_d", 32'(stallD), 32'(expStall));
    checkOutput("flush_e", 32'(flushE), 32'(expStall));
    checkOutput("flush_d", 32'(flushD), 32'(expFlush));
    checkOutput("md_busy", 32'(mdBusy), 32'(modelBusy()));
    checkOutput("stall_cnt", 32'(stallCnt), 32'(stallEvents));
    checkOutput("flush_cnt", 32'(flushCnt), 32'(flushEvents));
    checkOutput("sat_stall_cnt", 32'(satStallCnt), 32'(satStallEvents));
    checkOutput("sat_flush_cnt", 32'(satFlushCnt), 32'(satFlushEvents));
    if (!rst_n) begin
      mdValid = 1'b0;
      stallEvents = 0; flushEvents = 0; satStallEvents = 0; satFlushEvents = 0;
    end else begin
      if (mdStartE) begin
        mdValid = 1'b1;
        mdStartCycle = cycleNum;
      end
      if (cntClr) begin
        stallEvents = 0; flushEvents = 0; satStallEvents = 0; satFlushEvents = 0;
      end else begin
        if (expStall && stallEvents < (1 << CNT_W) - 1) stallEvents++;
        if (expFlush && flushEvents < (1 << CNT_W) - 1) flushEvents++;
        if (expStall && satStallEvents < (1 << SAT_W) - 1) satStallEvents++;
        if (expFlush && satFlushEvents < (1 << SAT_W) - 1) satFlushEvents++;
      end
    end
    cycleNum++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    clearInputs();
    applyStimulus();

    // Forwarding priority and the zero register
    rsE = 3; wrM = 3; rwM = 1; wrW = 3; rwW = 1;
    applyStimulus();
    checkOutput("fwd_m_priority", 32'(fwdAE), 32'd2);
    rwM = 0;
    applyStimulus();
    rsE = 0; rtE = 0; wrM = 0; wrW = 0; wrE = 0; rwM = 1; rwE = 1;
    applyStimulus();
    clearInputs();

    // Load-use on rt_d, then the same with a zero destination
    mtrE = 1; wrE = 5; rtD = 5; rtE = 9;
    applyStimulus();
    wrE = 0;
    applyStimulus();
    clearInputs();

    // Branch waiting on E, then resolved with M forwarding
    brD = 1; rsD = 7; rwE = 1; wrE = 7; brTakenD = 1;
    applyStimulus();
    rwE = 0; wrE = 0; wrM = 7; rwM = 1; mtrM = 0;
    applyStimulus();
    checkOutput("branch_flush_cnt", 32'(flushCnt), 32'd1);
    clearInputs();

    // Mult/div issue with a dependent D instruction held behind it
    mdStartE = 1; mdUseD = 1;
    applyStimulus();
    mdStartE = 0;
    repeat (6) applyStimulus();
    mdStartE = 1;
    applyStimulus();
    mdStartE = 0;
    applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("reset_drops_busy", 32'(mdBusy), 32'd0);
    clearInputs();

    // Long stall run saturates the narrow counter, then clear wins over a stall
    mtrE = 1; wrE = 4; rsD = 4;
    repeat (9) applyStimulus();
    applyStimulus();
    checkOutput("sat_at_max", 32'(satStallCnt), 32'd7);
    cntClr = 1;
    applyStimulus();
    cntClr = 0;
    applyStimulus();
    clearInputs();

    // Random traffic over a small register set to force frequent collisions
    for (int i = 0; i < 3000; i++) begin
      rsD = REG_AW'($urandom_range(0, 3)); rtD = REG_AW'($urandom_range(0, 3));
      rsE = REG_AW'($urandom_range(0, 3)); rtE = REG_AW'($urandom_range(0, 3));
      wrE = REG_AW'($urandom_range(0, 3)); wrM = REG_AW'($urandom_range(0, 3));
      wrW = REG_AW'($urandom_range(0, 3));
      rwE = 1'($urandom); rwM = 1'($urandom); rwW = 1'($urandom);
      mtrE = ($urandom_range(0, 3) == 0); mtrM = ($urandom_range(0, 3) == 0);
      brD = 1'($urandom); brTakenD = 1'($urandom);
      mdStartE = ($urandom_range(0, 9) == 0); mdUseD = 1'($urandom);
      cntClr = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W). It generates E-stage and D-stage forwarding selects, load-use and branch-operand stalls, and taken-branch flushes. It adds a busy scoreboard for the multi-cycle multiply/divide unit (HI/LO) and saturating stall/flush event counters. It sits beside the datapath, exchanges only control signals, and drives the F/D pipeline-register enables and the D/E flushes.

## Interface
- `REG_AW`, 5, register address width; address 0 is the hardwired zero register.
- `MD_LAT`, 4, multiply/divide latency in cycles (0 = single-cycle unit, scoreboard disabled).
- `CNT_W`, 16, width of the event counters.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rs_d`, `rt_d`  in  REG_AW  source registers of the D-stage instruction.
- `rs_e`, `rt_e`  in  REG_AW  source registers of the E-stage instruction.
- `write_reg_e`, `write_reg_m`, `write_reg_w`  in  REG_AW  destination register per stage.
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1  register-write enable per stage.
- `mem_to_reg_e`, `mem_to_reg_m`  in  1  the instruction in that stage is a load.
- `branch_d`  in  1  D instruction is a branch that compares in D.
- `branch_taken_d`  in  1  D comparator result (valid only when `branch_d`).
- `md_start_e`  in  1  a mult/div is in E this cycle and issues to the unit.
- `md_use_d`  in  1  D instruction reads HI/LO or is itself a mult/div.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `forward_a_e`, `forward_b_e`  out  2  E operand select: 10 = M result, 01 = W result, 00 = register file.
- `forward_a_d`, `forward_b_d`  out  1  D comparator operand taken from M ALU result.
- `stall_f`, `stall_d`  out  1  hold the PC and the F/D register.
- `flush_d`, `flush_e`  out  1  clear the F/D register (squash fetched instruction) or the D/E register (bubble).
- `md_busy`  out  1  mult/div result not yet available.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- E forwarding, per operand X in {rs_e, rt_e}:
  - 10 if X≠0, X==write_reg_m and reg_write_m.
  - Otherwise 01 if X≠0, X==write_reg_w and reg_write_w.
  - Otherwise 00. M has priority because it holds the newer value.
- D forwarding: `forward_a_d` = rs_d≠0 & rs_d==write_reg_m & reg_write_m & !mem_to_reg_m. `forward_b_d` is the same with rt_d.
- Match term: `match(R)` = R≠0 & (R==rs_d | R==rt_d).
- load_use = mem_to_reg_e & match(write_reg_e). The destination is compared, not rt_e.
- branch_stall = branch_d & ((reg_write_e & match(write_reg_e)) | (mem_to_reg_m & match(write_reg_m))).
- md_stall = md_use_d & md_busy.
- stall = load_use | branch_stall | md_stall.
  - `stall_f` = `stall_d` = `flush_e` = stall.
- flush_d = branch_d & branch_taken_d & !stall. A stalled branch is not resolved.
- Scoreboard: down-counter `md_cnt`, width clog2(MD_LAT+1).
  - md_start_e loads MD_LAT; otherwise the counter decrements when nonzero.
  - `md_busy` = md_cnt≠0.
  - md_start_e while busy is a protocol violation; the counter reloads MD_LAT regardless.
  - MD_LAT=0: md_busy is constant 0.
- Counters:
  - `stall_cnt` +1 in every cycle stall=1; `flush_cnt` +1 in every cycle flush_d=1.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr has priority over increment and clears to 0 at the edge.

## Timing
- Forwarding, stall and flush outputs are combinational from the current inputs and `md_cnt`.
- `md_busy` and the counters are registered.
- md_start_e in cycle t: md_busy=1 in cycles t+1..t+MD_LAT and 0 from t+MD_LAT+1. md_use_d is stalled through t+MD_LAT and proceeds in t+MD_LAT+1.
- Counters reflect an event one cycle after it.
- Reset (rst_n=0 at an edge): md_cnt=0, md_busy=0, stall_cnt=0, flush_cnt=0.
  - Reset overrides md_start_e and cnt_clr in the same cycle.
  - Reset mid mult/div drops md_busy the next cycle; the pending result is abandoned.
- Combinational outputs are not gated by reset. With all inputs 0 they are 0 (forward selects 00).
- Simultaneous load_use and md_stall: one stall cycle is counted, not two.

## Test plan
- Forwarding priority and zero register:
  - rs_e=3, write_reg_m=3, reg_write_m=1, write_reg_w=3, reg_write_w=1 -> forward_a_e=10.
  - Clearing reg_write_m -> 01.
  - rs_e=0 with all writers targeting 0 -> 00.
- Load-use: mem_to_reg_e=1, write_reg_e=5, rt_d=5, rt_e=9 -> stall_f/stall_d/flush_e=1, stall_cnt=1 the next cycle. Same case with write_reg_e=0 -> no stall.
- Branch: branch_d=1, rs_d=7.
  - reg_write_e=1, write_reg_e=7 -> stall=1, flush_d=0 even if branch_taken_d=1.
  - Next cycle, write_reg_m=7, reg_write_m=1, mem_to_reg_m=0, branch_taken_d=1 -> forward_a_d=1, stall=0, flush_d=1, flush_cnt increments.
- Mult/div scoreboard (MD_LAT=4): md_start_e at cycle 10, md_use_d held high -> md_busy and stall high in cycles 11–14, both low in cycle 15, stall_cnt increases by 4.
- Reset and clear:
  - rst_n=0 in cycle 12 of the previous case -> md_busy=0 from cycle 13, counters 0.
  - With CNT_W=3 and 9 consecutive stalls -> stall_cnt saturates at 7.
  - cnt_clr together with a stall -> stall_cnt=0.
